// File: rtl/hurricane_timer_pkg.sv
// Shared smoker range-hood definitions.
// Holds the mode FSM encodings, the default tick rate, the hurricane countdown
// state type and a small saturating seconds helper shared by the countdown stages.
package hurricane_timer_pkg;

  // Mode encodings driven by the range-hood mode FSM.
  localparam logic [2:0] MODE_STANDBY   = 3'b000;
  localparam logic [2:0] MODE_1         = 3'b001;
  localparam logic [2:0] MODE_2         = 3'b010;
  localparam logic [2:0] MODE_HURRICANE = 3'b011;
  localparam logic [2:0] MODE_CLEAN     = 3'b100;
  localparam logic [2:0] MODE_CUMTIME   = 3'b111;

  // System clock cycles per one-second tick.
  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;

  // Width of every seconds counter exported to the display logic.
  localparam int unsigned SecW = 7;

  // Hurricane countdown states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_MENU = 2'd2,
    DONE     = 2'd3
  } hur_state_e;

  // Decrement that stops at zero; seconds counters never wrap.
  function automatic logic [SecW-1:0] sec_dec_sat(input logic [SecW-1:0] sec);
    logic [SecW-1:0] res;
    res = (sec == '0) ? '0 : sec - 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/hurricane_timer_sec_tick_gen.sv
// One-second tick generator.
// Counts 0..CLK_HZ-1 while enabled and pulses tick for the single cycle in
// which the count sits at CLK_HZ-1, after which it wraps to 0. clear forces
// the count to 0 and takes priority over counting. Counting holds while disabled.
//
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   enable_i  count while high
//   clear_i   synchronous clear of the count
//   tick_o    one-cycle pulse once per CLK_HZ enabled cycles
module sec_tick_gen
  import hurricane_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  // A 1 Hz clock still needs a one-bit counter to stay legal.
  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hurricane_timer.sv
// Hurricane-mode countdown stage for the smoker range hood.
// Watches the mode FSM; when the hood enters hurricane mode it runs a
// HURRICANE_SEC countdown and then drops hurricane_mode_enabled so the mode
// FSM leaves mode 3. One menu press during the run reloads the countdown once
// and redirects the exit to standby. Only one hurricane use is allowed per
// power-on session; powering the hood off re-arms it.
//
// Ports:
//   clk_i                     system clock
//   rst_ni                    asynchronous active-low reset
//   machine_state_i           1 = hood powered on
//   mode_state_i              current mode, MODE_HURRICANE = hurricane
//   menu_btn_i                debounced menu button level
//   hurricane_mode_enabled_o  1 = entry allowed / running; falling edge = exit mode 3
//   return_state_o            exit target: 1 = gear 2, 0 = standby
//   remaining_sec_o           seconds left in the countdown, 0 when idle
//   active_o                  1 while a countdown runs
//
// HURRICANE_SEC must lie in 1..127 so it fits the 7-bit seconds output.
module hurricane_timer
  import hurricane_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int unsigned HURRICANE_SEC = 60
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            machine_state_i,
  input  logic [2:0]      mode_state_i,
  input  logic            menu_btn_i,
  output logic            hurricane_mode_enabled_o,
  output logic            return_state_o,
  output logic [SecW-1:0] remaining_sec_o,
  output logic            active_o
);

  localparam logic [SecW-1:0] ReloadSec = SecW'(HURRICANE_SEC);

  hur_state_e      state_q, state_d;
  logic            enabled_q, enabled_d;
  logic            return_q, return_d;
  logic [SecW-1:0] remaining_q, remaining_d;
  logic            active_q, active_d;
  logic            menu_btn_q;

  logic menu_edge;
  logic in_hurricane;
  logic tick;
  logic tick_clear;

  assign menu_edge    = menu_btn_i & ~menu_btn_q;
  assign in_hurricane = (mode_state_i == MODE_HURRICANE);

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (active_q),
    .clear_i  (tick_clear),
    .tick_o   (tick)
  );

  always_comb begin
    state_d     = state_q;
    enabled_d   = enabled_q;
    return_d    = return_q;
    remaining_d = remaining_q;
    active_d    = active_q;
    tick_clear  = 1'b0;

    if (!machine_state_i) begin
      // Power-off re-arms the session and beats every other event.
      state_d     = IDLE;
      enabled_d   = 1'b1;
      return_d    = 1'b1;
      remaining_d = '0;
      active_d    = 1'b0;
      tick_clear  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_hurricane && enabled_q) begin
            state_d     = RUN;
            remaining_d = ReloadSec;
            active_d    = 1'b1;
            return_d    = 1'b1;
            tick_clear  = 1'b1;
          end
        end

        RUN, RUN_MENU: begin
          if (!in_hurricane) begin
            // Mode FSM left mode 3 on its own: the use is still consumed.
            state_d     = DONE;
            enabled_d   = 1'b0;
            active_d    = 1'b0;
            remaining_d = '0;
          end else if ((state_q == RUN) && menu_edge) begin
            // The single reload; it wins over a coincident final tick.
            state_d     = RUN_MENU;
            remaining_d = ReloadSec;
            return_d    = 1'b0;
            tick_clear  = 1'b1;
          end else if (tick) begin
            if (remaining_q <= SecW'(1)) begin
              state_d     = DONE;
              remaining_d = '0;
              enabled_d   = 1'b0;
              active_d    = 1'b0;
            end else begin
              remaining_d = sec_dec_sat(remaining_q);
            end
          end
        end

        DONE: begin
          // Locked out until power-off; return_state keeps the last exit target.
          enabled_d   = 1'b0;
          active_d    = 1'b0;
          remaining_d = '0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      enabled_q   <= 1'b1;
      return_q    <= 1'b1;
      remaining_q <= '0;
      active_q    <= 1'b0;
      menu_btn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      enabled_q   <= enabled_d;
      return_q    <= return_d;
      remaining_q <= remaining_d;
      active_q    <= active_d;
      menu_btn_q  <= menu_btn_i;
    end
  end

  assign hurricane_mode_enabled_o = enabled_q;
  assign return_state_o           = return_q;
  assign remaining_sec_o          = remaining_q;
  assign active_o                 = active_q;

endmodule

// File: tb/tb_hurricane_timer.sv
module tb_hurricane_timer;

  localparam int unsigned CLK = 10;
  localparam int unsigned SEC = 5;

  logic       clk_i;
  logic       rst_ni;
  logic       machine_state;
  logic [2:0] mode_state;
  logic       menu_btn;
  logic       enabled_o;
  logic       return_o;
  logic [6:0] remaining_o;
  logic       active_o;

  int n_checks;
  int n_fail;

  hurricane_timer #(
    .CLK_HZ        (CLK),
    .HURRICANE_SEC (SEC)
  ) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .machine_state_i          (machine_state),
    .mode_state_i             (mode_state),
    .menu_btn_i               (menu_btn),
    .hurricane_mode_enabled_o (enabled_o),
    .return_state_o           (return_o),
    .remaining_sec_o          (remaining_o),
    .active_o                 (active_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: a countdown is "elapsed cycles since start or reload";
  // remaining seconds follow by division, expiry at SEC*CLK elapsed cycles.
  bit m_running;
  bit m_menu_used;
  bit m_done;
  bit m_en;
  bit m_ret;
  bit m_prev_btn;
  int m_elapsed;

  task automatic model_reset();
    m_running   = 1'b0;
    m_menu_used = 1'b0;
    m_done      = 1'b0;
    m_en        = 1'b1;
    m_ret       = 1'b1;
    m_prev_btn  = 1'b0;
    m_elapsed   = 0;
  endtask

  task automatic model_step();
    bit pressed;
    pressed    = menu_btn && !m_prev_btn;
    m_prev_btn = menu_btn;
    if (!machine_state) begin
      m_running = 1'b0;
      m_done    = 1'b0;
      m_en      = 1'b1;
      m_ret     = 1'b1;
      m_elapsed = 0;
    end else if (m_running) begin
      if (mode_state != 3'd3) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        m_en      = 1'b0;
      end else if (pressed && !m_menu_used) begin
        m_menu_used = 1'b1;
        m_elapsed   = 0;
        m_ret       = 1'b0;
      end else begin
        m_elapsed++;
        if (m_elapsed >= int'(SEC * CLK)) begin
          m_running = 1'b0;
          m_done    = 1'b1;
          m_en      = 1'b0;
        end
      end
    end else if (!m_done && mode_state == 3'd3) begin
      m_running   = 1'b1;
      m_menu_used = 1'b0;
      m_elapsed   = 0;
      m_ret       = 1'b1;
    end
  endtask

  function automatic logic [6:0] exp_rem();
    return m_running ? 7'(int'(SEC) - m_elapsed / int'(CLK)) : 7'd0;
  endfunction

  // Advance one clock; the model sees the inputs that were present at the edge.
  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic power_cycle();
    machine_state = 1'b0;
    mode_state    = 3'd0;
    menu_btn      = 1'b0;
    step();
    machine_state = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni        = 1'b0;
    machine_state = 1'b0;
    mode_state    = 3'd0;
    menu_btn      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (enabled_o !== 1'b1 || return_o !== 1'b1 || remaining_o !== 7'd0 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: en=%b ret=%b rem=%0d act=%b, want en=1 ret=1 rem=0 act=0",
               enabled_o, return_o, remaining_o, active_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_full_countdown();
    logic [6:0] want_at[int];
    want_at[1]  = 7'd5;
    want_at[11] = 7'd4;
    want_at[21] = 7'd3;
    want_at[31] = 7'd2;
    want_at[50] = 7'd1;
    want_at[51] = 7'd0;
    machine_state = 1'b1;
    mode_state    = 3'd3;
    for (int k = 1; k <= 55; k++) begin
      step();
      n_checks++;
      if (remaining_o !== exp_rem() || active_o !== m_running || enabled_o !== m_en ||
          return_o !== m_ret) begin
        n_fail++;
        $display("FAIL countdown cyc %0d: rem=%0d act=%b en=%b ret=%b, want rem=%0d act=%b en=%b ret=%b",
                 k, remaining_o, active_o, enabled_o, return_o, exp_rem(), m_running, m_en, m_ret);
      end
      if (want_at.exists(k)) begin
        n_checks++;
        if (remaining_o !== want_at[k]) begin
          n_fail++;
          $display("FAIL countdown_fixed cyc %0d: rem=%0d, want %0d", k, remaining_o, want_at[k]);
        end
      end
    end
    n_checks++;
    if (enabled_o !== 1'b0 || return_o !== 1'b1 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL countdown_end: en=%b ret=%b act=%b, want en=0 ret=1 act=0",
               enabled_o, return_o, active_o);
    end
  endtask

  task automatic test_done_lockout();
    for (int k = 0; k < 20; k++) begin
      step();
      n_checks++;
      if (enabled_o !== 1'b0 || active_o !== 1'b0 || remaining_o !== 7'd0) begin
        n_fail++;
        $display("FAIL lockout cyc %0d: en=%b act=%b rem=%0d, want en=0 act=0 rem=0",
                 k, enabled_o, active_o, remaining_o);
      end
    end
    machine_state = 1'b0;
    step();
    n_checks++;
    if (enabled_o !== 1'b1 || return_o !== 1'b1 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL power_off: en=%b ret=%b act=%b, want en=1 ret=1 act=0",
               enabled_o, return_o, active_o);
    end
    machine_state = 1'b1;
    step();
    n_checks++;
    if (remaining_o !== 7'd5 || active_o !== 1'b1 || enabled_o !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: rem=%0d act=%b en=%b, want rem=5 act=1 en=1",
               remaining_o, active_o, enabled_o);
    end
  endtask

  task automatic test_menu_reload();
    power_cycle();
    mode_state = 3'd3;
    step();
    repeat (23) step();
    menu_btn = 1'b1;
    step();
    n_checks++;
    if (remaining_o !== 7'd5 || return_o !== 1'b0 || enabled_o !== 1'b1) begin
      n_fail++;
      $display("FAIL menu_reload: rem=%0d ret=%b en=%b, want rem=5 ret=0 en=1",
               remaining_o, return_o, enabled_o);
    end
    for (int k = 1; k <= 52; k++) begin
      // A second press mid-run must not reload again.
      menu_btn = (k >= 5 && k < 8) ? 1'b0 : 1'b1;
      step();
      n_checks++;
      if (remaining_o !== exp_rem() || active_o !== m_running || enabled_o !== m_en ||
          return_o !== m_ret) begin
        n_fail++;
        $display("FAIL menu_run cyc %0d: rem=%0d act=%b en=%b ret=%b, want rem=%0d act=%b en=%b ret=%b",
                 k, remaining_o, active_o, enabled_o, return_o, exp_rem(), m_running, m_en, m_ret);
      end
      if (k == 49 || k == 50) begin
        n_checks++;
        if (enabled_o !== (k == 49 ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL menu_expiry cyc %0d: en=%b, want %b", k, enabled_o, (k == 49));
        end
      end
    end
    menu_btn = 1'b0;
    n_checks++;
    if (enabled_o !== 1'b0 || return_o !== 1'b0 || remaining_o !== 7'd0) begin
      n_fail++;
      $display("FAIL menu_end: en=%b ret=%b rem=%0d, want en=0 ret=0 rem=0",
               enabled_o, return_o, remaining_o);
    end
  endtask

  task automatic test_menu_final_tick();
    power_cycle();
    mode_state = 3'd3;
    step();
    // Rising edge lands exactly on the cycle that carries the last tick.
    for (int k = 0; k < 100 && m_elapsed < int'(SEC * CLK) - 1; k++) step();
    n_checks++;
    if (remaining_o !== 7'd1 || active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL final_tick_setup: rem=%0d act=%b, want rem=1 act=1", remaining_o, active_o);
    end
    menu_btn = 1'b1;
    step();
    n_checks++;
    if (remaining_o !== 7'd5 || enabled_o !== 1'b1 || return_o !== 1'b0 || active_o !== 1'b1) begin
      n_fail++;
      $display("FAIL final_tick_menu: rem=%0d en=%b ret=%b act=%b, want rem=5 en=1 ret=0 act=1",
               remaining_o, enabled_o, return_o, active_o);
    end
    menu_btn = 1'b0;
  endtask

  task automatic test_external_exit();
    power_cycle();
    mode_state = 3'd3;
    step();
    for (int k = 0; k < 100 && exp_rem() != 7'd3; k++) step();
    n_checks++;
    if (remaining_o !== 7'd3) begin
      n_fail++;
      $display("FAIL exit_setup: rem=%0d, want 3", remaining_o);
    end
    mode_state = 3'd0;
    step();
    n_checks++;
    if (active_o !== 1'b0 || remaining_o !== 7'd0 || enabled_o !== 1'b0) begin
      n_fail++;
      $display("FAIL external_exit: act=%b rem=%0d en=%b, want act=0 rem=0 en=0",
               active_o, remaining_o, enabled_o);
    end
  endtask

  task automatic test_async_reset();
    power_cycle();
    mode_state = 3'd3;
    menu_btn   = 1'b0;
    repeat (15) step();
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (enabled_o !== 1'b1 || return_o !== 1'b1 || remaining_o !== 7'd0 || active_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: en=%b ret=%b rem=%0d act=%b, want en=1 ret=1 rem=0 act=0",
               enabled_o, return_o, remaining_o, active_o);
    end
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    power_cycle();
    for (int k = 0; k < 3000; k++) begin
      machine_state = ($urandom_range(0, 149) != 0);
      mode_state    = ($urandom_range(0, 9) < 8) ? 3'd3 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) menu_btn = ~menu_btn;
      step();
      n_checks++;
      if (remaining_o !== exp_rem() || active_o !== m_running || enabled_o !== m_en ||
          return_o !== m_ret) begin
        n_fail++;
        $display("FAIL random cyc %0d: rem=%0d act=%b en=%b ret=%b, want rem=%0d act=%b en=%b ret=%b",
                 k, remaining_o, active_o, enabled_o, return_o, exp_rem(), m_running, m_en, m_ret);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_full_countdown();
    test_done_lockout();
    test_menu_reload();
    test_menu_final_tick();
    test_external_exit();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
